// File: rtl/dcache_axi_engine_pkg.sv
// Shared constants, state encoding and burst helpers for the dcache AXI refill/writeback engine.
package dcache_axi_engine_pkg;

   localparam int unsigned BEAT_W         = 32;
   localparam int unsigned LINE_BEATS_DEF = 8;

   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WB_AW = 3'd1,
      ST_WB_W  = 3'd2,
      ST_WB_B  = 3'd3,
      ST_RD_AR = 3'd4,
      ST_RD_R  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // AXI4 LEN field is beats-1
   function automatic logic [7:0] burst_len(input int unsigned beats);
      return 8'(beats - 1);
   endfunction

endpackage

// File: rtl/dcache_axi_engine.sv
// Dcache line engine: optional dirty-victim AXI write burst followed by a line refill read burst.
module dcache_axi_engine
   import dcache_axi_engine_pkg::*;
#(
   parameter int unsigned LINE_BEATS = LINE_BEATS_DEF,
   parameter logic [3:0]  AXI_ID     = 4'd1
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           rd_req,
   input  logic [31:0]                    rd_addr,
   input  logic                           wr_req,
   input  logic [31:0]                    wr_addr,
   input  logic [BEAT_W*LINE_BEATS-1:0]   wb_line,
   output logic                           reload,
   output logic [BEAT_W*LINE_BEATS-1:0]   refill_line,
   output logic [3:0]                     arid,
   output logic [31:0]                    araddr,
   output logic [7:0]                     arlen,
   output logic [2:0]                     arsize,
   output logic [1:0]                     arburst,
   output logic                           arvalid,
   input  logic                           arready,
   input  logic [3:0]                     rid,
   input  logic [31:0]                    rdata,
   input  logic [1:0]                     rresp,
   input  logic                           rlast,
   input  logic                           rvalid,
   output logic                           rready,
   output logic [3:0]                     awid,
   output logic [31:0]                    awaddr,
   output logic [7:0]                     awlen,
   output logic [2:0]                     awsize,
   output logic [1:0]                     awburst,
   output logic                           awvalid,
   input  logic                           awready,
   output logic [31:0]                    wdata,
   output logic [3:0]                     wstrb,
   output logic                           wlast,
   output logic                           wvalid,
   input  logic                           wready,
   input  logic [1:0]                     bresp,
   input  logic                           bvalid,
   output logic                           bready
);

   localparam int unsigned     CNT_W     = $clog2(LINE_BEATS);
   localparam int unsigned     LINE_W    = BEAT_W * LINE_BEATS;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic [31:0]         rd_addr_q;
   logic [31:0]         wr_addr_q;
   logic [LINE_W-1:0]   wb_line_q;
   logic                unused_ok;

   assign cnt_inc = cnt + CNT_W'(1);

   // Burst shape is fixed: one full line of 32-bit INCR beats
   assign arid    = AXI_ID;
   assign araddr  = rd_addr_q;
   assign arlen   = burst_len(LINE_BEATS);
   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;
   assign awid    = AXI_ID;
   assign awaddr  = wr_addr_q;
   assign awlen   = burst_len(LINE_BEATS);
   assign awsize  = AXI_SIZE_4B;
   assign awburst = AXI_BURST_INCR;
   assign wstrb   = AXI_STRB_ALL;

   // Response id/status carry no information this engine acts on
   assign unused_ok = ^{rid, rresp, bresp};

   // Request capture and write-data staging; no reset needed
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && rd_req) begin
         rd_addr_q <= rd_addr;
         if (wr_req) begin
            wr_addr_q <= wr_addr;
            wb_line_q <= wb_line;
            wdata     <= wb_line[BEAT_W-1:0];
         end
      end else if (state == ST_WB_W && wready) begin
         wdata <= wb_line_q[BEAT_W*int'(cnt_inc) +: BEAT_W];
      end
   end

   // Control FSM with registered channel outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         wlast       <= 1'b0;
         bready      <= 1'b0;
         reload      <= 1'b0;
         refill_line <= '0;
      end else begin
         reload <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_req) begin
                  if (wr_req) begin
                     awvalid <= 1'b1;
                     state   <= ST_WB_AW;
                  end else begin
                     arvalid <= 1'b1;
                     state   <= ST_RD_AR;
                  end
               end
            end
            ST_WB_AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  wlast   <= (LAST_BEAT == '0);
                  cnt     <= '0;
                  state   <= ST_WB_W;
               end
            end
            ST_WB_W: begin
               if (wready) begin
                  if (wlast) begin
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                     state  <= ST_WB_B;
                  end else begin
                     cnt   <= cnt_inc;
                     wlast <= (cnt_inc == LAST_BEAT);
                  end
               end
            end
            ST_WB_B: begin
               if (bvalid) begin
                  bready  <= 1'b0;
                  arvalid <= 1'b1;
                  state   <= ST_RD_AR;
               end
            end
            ST_RD_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (rvalid) begin
                  refill_line[BEAT_W*int'(cnt) +: BEAT_W] <= rdata;
                  cnt <= cnt_inc;
                  if (rlast) begin
                     rready <= 1'b0;
                     reload <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
